thermo_frame_gen: RTL
=====================

# thermo_frame_gen

Transmit-side counterpart of the thermometer summation path. Accepts one binary level per sample, expands each level into an OSF-bit thermometer code, and packs SAMPLES codes into one SAMPLES*OSF-bit frame. Completed frames are presented on a valid/ready output port. The frame layout is the one the receive-side summation stage consumes, so the frame's popcount equals the sum of the accepted levels.

## Interface
Parameters:
- SAMPLES, 2: thermometer codes per frame (≥1).
- OSF, 8: oversampling factor, i.e. bits per thermometer code (≥2).
- LW (localparam), $clog2(OSF)+1: level width, able to represent 0..OSF.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: when low, stalls acceptance and flush. State, frame and out_valid are held; output handshake still completes.
- in_level, input, LW: binary level of one sample.
- in_valid, input, 1: in_level is valid.
- in_ready, output, 1: the block can accept in_level this cycle.
- flush, input, 1: close a partially filled frame early.
- out_frame, output, SAMPLES*OSF: packed thermometer frame.
- out_sat, output, 1: at least one level in this frame was clamped.
- out_valid, output, 1: out_frame and out_sat are valid.
- out_ready, input, 1: downstream accepts the frame.

## Operation
- Two-state FSM.
  - FILL: in_ready = enable.
  - HOLD: in_ready = 0, out_valid = 1.
- Slot index idx counts 0..SAMPLES-1.
  - The sample accepted at idx k goes to out_frame[k*OSF+OSF-1 : k*OSF].
  - The first accepted sample lands in the LSB slot.
- Thermometer encoding: level L sets the low L bits of its slot; all other bits in the slot are 0.
  - L=0 gives all zeros.
  - L=OSF gives all ones.
- Saturation: L > OSF is clamped to OSF and sets the per-frame sat flag, which is cleared when the next frame starts.
- An accept happens when in_valid & in_ready.
  - Accept with idx < SAMPLES-1: write the slot, idx+1.
  - Accept with idx = SAMPLES-1: write the slot and go to HOLD.
- flush (FILL, enable=1):
  - Unfilled slots stay 0, the FSM goes to HOLD, and idx resets.
  - flush with a simultaneous accept: the accepted sample is stored first, then the frame closes.
  - flush at idx=0 with no accept is ignored; empty frames are never emitted.
- flush during HOLD or with enable=0 is ignored and is not remembered.
- HOLD with out_ready=1: frame consumed.
  - Go to FILL, idx=0, internal frame register and sat cleared.
  - out_frame keeps its value until overwritten.
- Before reaching HOLD, the frame register holds slots written so far; unwritten slots are 0.

## Timing
- Reset values: state FILL, idx 0, out_frame 0, out_sat 0, out_valid 0, in_ready equals enable.
- Reset overrides everything, including a partial frame (discarded) and a pending HOLD frame (dropped).
- Latency: out_valid rises the cycle after the final accept or the flush.
- out_frame and out_sat are registered and stable while out_valid=1.
- Throughput:
  - A full frame takes SAMPLES accept cycles plus at least 1 HOLD cycle.
  - With out_ready tied high: SAMPLES+1 cycles per frame.
- in_ready is combinational from state and enable only; it has no path from in_valid or out_ready.
- Backpressure: HOLD persists indefinitely while out_ready=0, with no frame or flag change.

## Structure
- Shared package `thermo_pkg` holds:
  - the LW function (clog2(OSF)+1);
  - FSM state enum {FILL, HOLD};
  - a function that computes slot bit offset k*OSF.
- Sub-module `bin2thermo` (combinational, OSF parameter): maps level to OSF-bit thermometer code plus a sat bit. It is instantiated once, on the input path.
- Top module owns the FSM, idx counter, frame register, sat flag and handshakes.

## Test plan
(SAMPLES=2, OSF=8)
- Levels 3 then 5, out_ready=1 → out_frame=0x1F07, out_sat=0, out_valid exactly one cycle, popcount 8.
- Levels 9 then 0 → out_frame=0x00FF, out_sat=1. Next frame with levels 8, 8 → 0xFFFF, out_sat=0.
- Levels 1, 2 with out_ready=0 for 5 cycles → in_ready=0 and out_frame=0x0301 held throughout. out_ready=1 → FILL the next cycle, new level 4 accepted into slot 0.
- Level 4, then flush alone → out_frame=0x000F.
  - flush at idx=0 with no in_valid → no frame.
  - flush together with accepting level 2 at idx 0 → 0x0003.
- enable=0 mid-frame (after level 6) for 3 cycles with in_valid=1 → nothing accepted. After enable=1, level 7 → 0x7F3F.
- reset asserted after one accepted sample → all outputs 0, next levels 2, 2 → 0x0303.

Source files
------------

// File: rtl/thermo_frame_gen_pkg.sv
// Shared definitions for the thermometer frame generator: level width, FSM states, slot offsets.
package thermo_pkg;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  // A level must represent 0..OSF inclusive.
  function automatic int lw_of(input int osf);
    return $clog2(osf) + 1;
  endfunction

  function automatic int slot_off(input int k, input int osf);
    return k * osf;
  endfunction

endpackage

// File: rtl/thermo_frame_gen_if.sv
// Sample-in / frame-out handshake bundle for thermo_frame_gen.
interface thermo_frame_gen_if #(
  parameter int SAMPLES = 2,
  parameter int OSF     = 8
);
  import thermo_pkg::*;

  localparam int LW = lw_of(OSF);

  logic [LW-1:0]          in_level;
  logic                   in_valid;
  logic                   in_ready;
  logic                   flush;
  logic [SAMPLES*OSF-1:0] out_frame;
  logic                   out_sat;
  logic                   out_valid;
  logic                   out_ready;

  modport slave (
    input  in_level, in_valid, flush, out_ready,
    output in_ready, out_frame, out_sat, out_valid
  );

  modport master (
    output in_level, in_valid, flush, out_ready,
    input  in_ready, out_frame, out_sat, out_valid
  );

endinterface

// File: rtl/thermo_frame_gen_bin2thermo.sv
// Binary level -> OSF-bit thermometer code; levels above OSF saturate to all ones.
module bin2thermo
  import thermo_pkg::*;
#(
  parameter int OSF = 8
) (
  input  logic [lw_of(OSF)-1:0] level,
  output logic [OSF-1:0]        code,
  output logic                  sat
);

  always_comb begin
    code = '0;
    for (int i = 0; i < OSF; i++) code[i] = (int'(level) > i);
    sat = (int'(level) > OSF);
  end

endmodule

// File: rtl/thermo_frame_gen.sv
// Packs SAMPLES thermometer codes into one frame and offers it on a valid/ready port.
module thermo_frame_gen
  import thermo_pkg::*;
#(
  parameter int SAMPLES = 2,
  parameter int OSF     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  thermo_frame_gen_if.slave   bus
);

  localparam int LW = lw_of(OSF);
  localparam int FW = SAMPLES * OSF;
  localparam int IW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  state_e          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [FW-1:0]   frame, frame_wr, out_frame_q;
  logic            sat_acc, sat_wr, out_sat_q;
  logic [OSF-1:0]  code;
  logic            code_sat;
  logic [LW-1:0]   level;
  logic            accept, last, do_flush, close, consume;

  assign level = bus.in_level;

  bin2thermo #(.OSF(OSF)) u_b2t (.level(level), .code(code), .sat(code_sat));

  assign accept   = bus.in_valid & bus.in_ready;
  assign last     = (idx == IW'(SAMPLES - 1));
  // An empty frame is never closed: flush needs a stored or simultaneous sample.
  assign do_flush = (state == FILL) & enable & bus.flush & (accept | (idx != '0));
  assign close    = (accept & last) | do_flush;
  assign consume  = (state == HOLD) & bus.out_ready;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (close)         state_nxt = HOLD;
      HOLD: if (bus.out_ready) state_nxt = FILL;
      default:                 state_nxt = FILL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      FILL: bus.in_ready  = enable;
      HOLD: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Current frame with this cycle's accepted sample merged in.
  always_comb begin
    frame_wr = frame;
    for (int k = 0; k < SAMPLES; k++)
      if (accept && idx == IW'(k)) frame_wr[slot_off(k, OSF) +: OSF] = code;
    sat_wr = sat_acc | (accept & code_sat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      frame       <= '0;
      sat_acc     <= 1'b0;
      out_frame_q <= '0;
      out_sat_q   <= 1'b0;
    end else if (consume) begin
      idx     <= '0;
      frame   <= '0;
      sat_acc <= 1'b0;
    end else if (state == FILL) begin
      if (close) begin
        idx         <= '0;
        frame       <= frame_wr;
        sat_acc     <= sat_wr;
        out_frame_q <= frame_wr;
        out_sat_q   <= sat_wr;
      end else if (accept) begin
        idx     <= idx + 1'b1;
        frame   <= frame_wr;
        sat_acc <= sat_wr;
      end
    end
  end

  assign bus.out_frame = out_frame_q;
  assign bus.out_sat   = out_sat_q;

endmodule
